// File: rtl/dma_channel_arbiter_if.sv
// Request/acknowledge bundle between the DMA arbiter and its surroundings
// (command/mask/request registers, CPU hold logic and the timing FSM).
//
// Handshake: HRQ/HLDA is a level-sensitive request/acknowledge pair. The
// arbiter raises HRQ and keeps it high until the grant ends; the CPU answers
// with HLDA, and the bus belongs to the DMA only while both are high. A grant
// ends on a one-cycle RELEASE pulse from the timing FSM or when the CPU drops
// HLDA. DACK/ACTIVE_CH are meaningful only while GRANT_VALID is high.
interface dma_channel_arbiter_if;
  logic [3:0] DREQ;
  logic       DREQ_ACTIVE_LOW;
  logic       DACK_ACTIVE_HIGH;
  logic       ROTATING_PRIO;
  logic       CTRL_DISABLE;
  logic [3:0] MASK;
  logic [3:0] SW_REQ;
  logic       HLDA;
  logic       RELEASE;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] ACTIVE_CH;
  logic       GRANT_VALID;
  logic [1:0] PRIO_PTR;
  logic [1:0] STATE_DBG;

  // Environment side: drives requests/configuration, observes the grant.
  modport master (
    output DREQ, DREQ_ACTIVE_LOW, DACK_ACTIVE_HIGH, ROTATING_PRIO,
           CTRL_DISABLE, MASK, SW_REQ, HLDA, RELEASE,
    input  HRQ, DACK, ACTIVE_CH, GRANT_VALID, PRIO_PTR, STATE_DBG
  );

  // Arbiter side.
  modport slave (
    input  DREQ, DREQ_ACTIVE_LOW, DACK_ACTIVE_HIGH, ROTATING_PRIO,
           CTRL_DISABLE, MASK, SW_REQ, HLDA, RELEASE,
    output HRQ, DACK, ACTIVE_CH, GRANT_VALID, PRIO_PTR, STATE_DBG
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// 4-channel DMA request arbiter and bus-hold sequencer. Qualifies hardware
// and software requests, requests the bus with HRQ, grants the winning
// channel on HLDA and holds the grant until RELEASE or loss of HLDA.
module dma_channel_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  dma_channel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic                              hrq_q, hrq_d;
  logic [NUM_CH-1:0]                 grant_oh_q, grant_oh_d;
  logic                              gv_q, gv_d;
  logic [1:0]                        ch_q, ch_d;
  logic [1:0]                        ptr_q, ptr_d;
  logic [NUM_CH-1:0]                 sw_req_q;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] dreq_sync_q;

  logic [NUM_CH-1:0] req_eff;
  logic              any_req;
  logic [1:0]        base_ptr;
  logic [1:0]        winner;

  // DREQ synchronizer; resets to the inactive level so no phantom request
  // appears on the first cycle after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        dreq_sync_q[s] <= {NUM_CH{bus.DREQ_ACTIVE_LOW}};
      end
      sw_req_q <= '0;
    end else begin
      dreq_sync_q[0] <= bus.DREQ;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        dreq_sync_q[s] <= dreq_sync_q[s-1];
      end
      sw_req_q <= bus.SW_REQ;
    end
  end

  // Request qualification: polarity-corrected, masked hardware requests
  // plus unmaskable software requests.
  always_comb begin
    req_eff = ((dreq_sync_q[SYNC_STAGES-1] ^ {NUM_CH{bus.DREQ_ACTIVE_LOW}})
               & ~bus.MASK) | sw_req_q;
    any_req = |req_eff;
  end

  // Priority search: scan from lowest to highest priority so the last hit,
  // i.e. the highest-priority requester, wins. Fixed mode starts at ch0.
  always_comb begin
    base_ptr = bus.ROTATING_PRIO ? ptr_q : 2'd0;
    winner   = base_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_eff[base_ptr + 2'(k)]) begin
        winner = base_ptr + 2'(k);
      end
    end
  end

  // State and grant registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      hrq_q      <= 1'b0;
      grant_oh_q <= '0;
      gv_q       <= 1'b0;
      ch_q       <= 2'd0;
      ptr_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      hrq_q      <= hrq_d;
      grant_oh_q <= grant_oh_d;
      gv_q       <= gv_d;
      ch_q       <= ch_d;
      ptr_q      <= ptr_d;
    end
  end

  // Next-state logic: IDLE -> REQ on a qualified request, REQ -> GRANT on
  // HLDA, GRANT -> IDLE on RELEASE (with rotation) or HLDA loss. Returning
  // through IDLE guarantees HRQ drops for a cycle between grants.
  always_comb begin
    state_d    = state_q;
    hrq_d      = hrq_q;
    grant_oh_d = grant_oh_q;
    gv_d       = gv_q;
    ch_d       = ch_q;
    ptr_d      = bus.ROTATING_PRIO ? ptr_q : 2'd0;

    case (state_q)
      ST_IDLE: begin
        hrq_d = 1'b0;
        if (any_req && !bus.CTRL_DISABLE) begin
          state_d = ST_REQ;
          hrq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (!any_req || bus.CTRL_DISABLE) begin
          state_d = ST_IDLE;
          hrq_d   = 1'b0;
        end else if (bus.HLDA) begin
          state_d            = ST_GRANT;
          ch_d               = winner;
          grant_oh_d         = '0;
          grant_oh_d[winner] = 1'b1;
          gv_d               = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.RELEASE || !bus.HLDA) begin
          state_d    = ST_IDLE;
          hrq_d      = 1'b0;
          grant_oh_d = '0;
          gv_d       = 1'b0;
          if (bus.RELEASE && bus.ROTATING_PRIO) begin
            ptr_d = ch_q + 2'd1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hrq_d      = 1'b0;
        grant_oh_d = '0;
        gv_d       = 1'b0;
      end
    endcase
  end

  // Output drive; DACK polarity follows the live command register bit.
  always_comb begin
    bus.HRQ         = hrq_q;
    bus.DACK        = grant_oh_q ^ {NUM_CH{~bus.DACK_ACTIVE_HIGH}};
    bus.ACTIVE_CH   = ch_q;
    bus.GRANT_VALID = gv_q;
    bus.PRIO_PTR    = ptr_q;
    bus.STATE_DBG   = state_q;
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed vector table covering the main
// scenarios and corner cases, then randomized traffic against a behavioural
// model of the arbitration rules.
module tb_dma_channel_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dma_channel_arbiter_if bus ();

  dma_channel_arbiter #(.NUM_CH(4), .SYNC_STAGES(1)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, dal, dah, rot, dis, hlda, rel;
    logic [3:0] dreq, mask, sw;
    logic       e_hrq;
    logic [3:0] e_dack;
    logic       e_gv;
    logic [1:0] e_ch, e_ptr;
    logic       chk_ch;
  } vec_t;

  vec_t vt[$];

  // Behavioural reference model
  logic [3:0] m_seen_dreq;
  logic [3:0] m_seen_sw;
  int         m_phase;   // 0 = bus not wanted, 1 = asking for bus, 2 = channel owns bus
  int         m_ch;
  int         m_ptr;
  bit         m_gv;

  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] req;
    int         base;
    if (rst) begin
      m_phase     = 0;
      m_gv        = 0;
      m_ch        = 0;
      m_ptr       = 0;
      m_seen_dreq = {4{bus.DREQ_ACTIVE_LOW}};
      m_seen_sw   = 4'h0;
      return;
    end
    req  = ((m_seen_dreq ^ {4{bus.DREQ_ACTIVE_LOW}}) & ~bus.MASK) | m_seen_sw;
    base = bus.ROTATING_PRIO ? m_ptr : 0;
    if (m_phase == 0) begin
      if (req != 0 && !bus.CTRL_DISABLE) m_phase = 1;
    end else if (m_phase == 1) begin
      if (req == 0 || bus.CTRL_DISABLE) m_phase = 0;
      else if (bus.HLDA) begin
        m_ch    = pick(req, base);
        m_gv    = 1;
        m_phase = 2;
      end
    end else begin
      if (bus.RELEASE) begin
        m_phase = 0;
        m_gv    = 0;
        if (bus.ROTATING_PRIO) m_ptr = (m_ch + 1) % 4;
      end else if (!bus.HLDA) begin
        m_phase = 0;
        m_gv    = 0;
      end
    end
    if (!bus.ROTATING_PRIO) m_ptr = 0;
    m_seen_dreq = bus.DREQ;
    m_seen_sw   = bus.SW_REQ;
  endtask

  // Driver tasks
  task automatic drive(input vec_t v);
    rst                  = v.rst;
    bus.DREQ_ACTIVE_LOW  = v.dal;
    bus.DACK_ACTIVE_HIGH = v.dah;
    bus.ROTATING_PRIO    = v.rot;
    bus.CTRL_DISABLE     = v.dis;
    bus.HLDA             = v.hlda;
    bus.RELEASE          = v.rel;
    bus.DREQ             = v.dreq;
    bus.MASK             = v.mask;
    bus.SW_REQ           = v.sw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t r(input logic [6:0] c, input logic [3:0] dq, input logic [3:0] mk,
                             input logic [3:0] sq, input logic eh, input logic [3:0] ed,
                             input logic eg, input logic [1:0] ec, input logic [1:0] ep,
                             input logic cc);
    vec_t v;
    {v.rst, v.dal, v.dah, v.rot, v.dis, v.hlda, v.rel} = c;
    v.dreq = dq; v.mask = mk; v.sw = sq;
    v.e_hrq = eh; v.e_dack = ed; v.e_gv = eg; v.e_ch = ec; v.e_ptr = ep; v.chk_ch = cc;
    return v;
  endfunction

  initial begin
    vec_t rv;
    logic [3:0] exp_dack;
    checks   = 0;
    failures = 0;

    // ctl = {rst, dal, dah, rot, dis, hlda, rel}; expectations hold after the edge
    //                 ctl         dreq   mask   sw     hrq  dack   gv  ch  ptr chk
    // reset
    vt.push_back(r(7'b1000000, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b1));
    vt.push_back(r(7'b1000000, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b1));
    // fixed priority, DREQ=1010: HRQ two edges later, ch1 then ch3
    vt.push_back(r(7'b0000000, 4'hA, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'hA, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000010, 4'hA, 4'h0, 4'h0, 1'b1, 4'hD, 1'b1, 2'd1, 2'd0, 1'b1));
    vt.push_back(r(7'b0000011, 4'h8, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000010, 4'h8, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000010, 4'h8, 4'h0, 4'h0, 1'b1, 4'h7, 1'b1, 2'd3, 2'd0, 1'b1));
    vt.push_back(r(7'b0000000, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    // rotating: ch1 -> ptr 2 -> ch3 wins (release+HLDA loss) -> ptr 0 -> ch0
    vt.push_back(r(7'b0001000, 4'h2, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0001000, 4'h2, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0001010, 4'h2, 4'h0, 4'h0, 1'b1, 4'hD, 1'b1, 2'd1, 2'd0, 1'b1));
    vt.push_back(r(7'b0001011, 4'hB, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd2, 1'b0));
    vt.push_back(r(7'b0001010, 4'hB, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd2, 1'b0));
    vt.push_back(r(7'b0001010, 4'hB, 4'h0, 4'h0, 1'b1, 4'h7, 1'b1, 2'd3, 2'd2, 1'b1));
    vt.push_back(r(7'b0001001, 4'hB, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0001000, 4'hB, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0001010, 4'hB, 4'h0, 4'h0, 1'b1, 4'hE, 1'b1, 2'd0, 2'd0, 1'b1));
    vt.push_back(r(7'b0001011, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd1, 1'b0));
    // mask blocks hardware request; software request wins despite mask
    vt.push_back(r(7'b0000000, 4'h1, 4'h1, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'h1, 4'h1, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'h1, 4'h1, 4'h1, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'h1, 4'h1, 4'h1, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000010, 4'h1, 4'h1, 4'h1, 1'b1, 4'hE, 1'b1, 2'd0, 2'd0, 1'b1));
    vt.push_back(r(7'b0000011, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    // request withdrawn while waiting for HLDA
    vt.push_back(r(7'b0000000, 4'h4, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'h4, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'h0, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0000000, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    // HLDA loss keeps PRIO_PTR; MASK/CTRL_DISABLE do not end a grant
    vt.push_back(r(7'b0001000, 4'h4, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0001000, 4'h4, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0001010, 4'h4, 4'h0, 4'h0, 1'b1, 4'hB, 1'b1, 2'd2, 2'd0, 1'b1));
    vt.push_back(r(7'b0001011, 4'h4, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd3, 1'b0));
    vt.push_back(r(7'b0001000, 4'h4, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd3, 1'b0));
    vt.push_back(r(7'b0001010, 4'h4, 4'h0, 4'h0, 1'b1, 4'hB, 1'b1, 2'd2, 2'd3, 1'b1));
    vt.push_back(r(7'b0001110, 4'h4, 4'hF, 4'h0, 1'b1, 4'hB, 1'b1, 2'd2, 2'd3, 1'b1));
    vt.push_back(r(7'b0001000, 4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd3, 1'b0));
    // inverted polarities: DREQ=1110 means ch0 requests, DACK=0001
    vt.push_back(r(7'b0110000, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110000, 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110000, 4'hE, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110010, 4'hE, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 2'd0, 1'b1));
    vt.push_back(r(7'b0110001, 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    // CTRL_DISABLE blocks in IDLE and withdraws in REQ
    vt.push_back(r(7'b0110100, 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110000, 4'hE, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110100, 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110000, 4'hE, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0));
    vt.push_back(r(7'b0110010, 4'hE, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0, 2'd0, 1'b1));
    // reset during a grant
    vt.push_back(r(7'b1110010, 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b1));

    drive(vt[0]);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      tick();
      check($sformatf("row%0d hrq", i),  8'(bus.HRQ),         8'(vt[i].e_hrq));
      check($sformatf("row%0d dack", i), 8'(bus.DACK),        8'(vt[i].e_dack));
      check($sformatf("row%0d gv", i),   8'(bus.GRANT_VALID), 8'(vt[i].e_gv));
      check($sformatf("row%0d ptr", i),  8'(bus.PRIO_PTR),    8'(vt[i].e_ptr));
      if (vt[i].chk_ch) check($sformatf("row%0d ch", i), 8'(bus.ACTIVE_CH), 8'(vt[i].e_ch));
    end

    // Randomized traffic against the reference model
    rv = vt[0];
    rv.rst = 1'b0; rv.dal = 1'b0; rv.dah = 1'b0; rv.rot = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rv.rst  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) rv.dal = ~rv.dal;
      if ($urandom_range(0, 59) == 0) rv.dah = ~rv.dah;
      if ($urandom_range(0, 39) == 0) rv.rot = ~rv.rot;
      rv.dis  = ($urandom_range(0, 9) == 0);
      rv.hlda = ($urandom_range(0, 4) != 0);
      rv.rel  = ($urandom_range(0, 3) == 0);
      rv.dreq = 4'($urandom);
      rv.mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      rv.sw   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      drive(rv);
      tick();
      exp_dack = (m_gv ? (4'b0001 << m_ch) : 4'h0) ^ {4{~bus.DACK_ACTIVE_HIGH}};
      check("rnd hrq",  8'(bus.HRQ),         8'(m_phase != 0));
      check("rnd dack", 8'(bus.DACK),        8'(exp_dack));
      check("rnd gv",   8'(bus.GRANT_VALID), 8'(m_gv));
      check("rnd ptr",  8'(bus.PRIO_PTR),    8'(m_ptr));
      if (m_gv) check("rnd ch", 8'(bus.ACTIVE_CH), 8'(m_ch));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
